// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg
//   Shared encodings for the multicycle MIPS control unit: FSM state codes,
//   instruction opcodes and the datapath mux/ALU select codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    ADDIEX = 4'd8,
    ADDIWB = 4'd9,
    BRANCH = 4'd10,
    JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] BNE   = 6'b000101;
  localparam logic [5:0] ADDI  = 6'b001000;
  localparam logic [5:0] J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] NE_NONE = 2'b00;
  localparam logic [1:0] NE_JUMP = 2'b10;

endpackage

// File: rtl/mc_control_if.sv
// mc_control_if
//   Bundle between the control unit and the datapath/memory.
//   Inputs to the controller : OpCode (instr[31:26]), mem_ready.
//   Outputs of the controller: datapath strobes, mux selects, ALUOp, Ne,
//                              illegal_op, mem_timeout, state.
//   master = control unit, slave = datapath side.
interface mc_control_if;
  logic [5:0] OpCode;
  logic       mem_ready;

  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic       IRWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       ALUSrcA;
  logic [1:0] ALUOp;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic [1:0] Ne;
  logic       illegal_op;
  logic       mem_timeout;
  logic [3:0] state;

  modport master (
    input  OpCode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           RegWrite, RegDst, ALUSrcA, ALUOp, ALUSrcB, PCSource, Ne,
           illegal_op, mem_timeout, state
  );

  modport slave (
    output OpCode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           RegWrite, RegDst, ALUSrcA, ALUOp, ALUSrcB, PCSource, Ne,
           illegal_op, mem_timeout, state
  );
endinterface

// File: rtl/mem_wait_timer.sv
// mem_wait_timer
//   Counts consecutive not-ready cycles in a memory-wait state.
//   clk, reset (async active-low), active (FSM is in a wait state),
//   ready (memory done), expired (MAX_WAIT not-ready cycles already spent
//   and memory still not ready this cycle).
module mem_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic ready,
  output logic expired
);

  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] TC_LOAD = CW'(MAX_WAIT);

  logic [CW-1:0] count_q, count_d;

  // Down-counter holds the remaining wait budget; zero means the budget
  // is spent, so a further not-ready cycle is the timeout cycle.
  assign expired = active & ~ready & (count_q == '0);

  always_comb begin
    count_d = count_q - CW'(1);
    if (!active || ready || expired) begin
      count_d = TC_LOAD;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= TC_LOAD;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mc_control.sv
// mc_control
//   Moore control FSM for a multicycle MIPS datapath (lw, sw, R-type,
//   addi, beq, bne, j) with a bounded wait on mem_ready.
//   clk   : rising-edge clock
//   reset : async active-low reset
//   bus   : mc_control_if.master (OpCode/mem_ready in, strobes/selects out)
//
//   state  | meaning
//   FETCH  | read instruction, PC += 4 when memory ready
//   DECODE | register read, branch target computed; dispatch on OpCode
//   MEMADR | lw/sw effective address
//   MEMRD  | data memory read, wait for ready
//   MEMWB  | load result to rt
//   MEMWR  | data memory write, wait for ready
//   EXEC   | R-type ALU operation
//   ALUWB  | R-type result to rd
//   ADDIEX | addi ALU operation
//   ADDIWB | addi result to rt
//   BRANCH | compare and conditional PC update (beq/bne)
//   JUMP   | PC <= jump address
module mc_control
  import mips_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic         clk,
  input  logic         reset,
  mc_control_if.master bus
);

  state_e     state_q, state_d;
  logic       active, expired;
  logic       pc_write, pc_write_cond, ior_d, mem_read, mem_write;
  logic       mem_to_reg, ir_write, reg_write, reg_dst, alu_src_a, illegal;
  logic [1:0] alu_op, alu_src_b, pc_source, ne;

  assign active = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);

  mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait (
    .clk    (clk),
    .reset  (reset),
    .active (active),
    .ready  (bus.mem_ready),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ior_d         = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    alu_src_a     = 1'b0;
    illegal       = 1'b0;
    alu_op        = ALUOP_ADD;
    alu_src_b     = SRCB_REG;
    pc_source     = PCSRC_ALU;
    ne            = NE_NONE;

    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end else begin
          state_d  = FETCH;
        end
      end
      DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        case (bus.OpCode)
          LW, SW:   state_d = MEMADR;
          RTYPE:    state_d = EXEC;
          ADDI:     state_d = ADDIEX;
          BEQ, BNE: state_d = BRANCH;
          J:        state_d = JUMP;
          default: begin
            state_d = FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        if (bus.OpCode == LW) begin
          state_d = MEMRD;
        end else if (bus.OpCode == SW) begin
          state_d = MEMWR;
        end else begin
          state_d = FETCH;
        end
      end
      MEMRD: begin
        ior_d    = 1'b1;
        mem_read = 1'b1;
        state_d  = bus.mem_ready ? MEMWB : MEMRD;
      end
      MEMWR: begin
        ior_d     = 1'b1;
        mem_write = 1'b1;
        state_d   = bus.mem_ready ? FETCH : MEMWR;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = ADDIWB;
      end
      ADDIWB: begin
        reg_write = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        ne            = {1'b0, (bus.OpCode == BNE)};
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
        ne        = NE_JUMP;
      end
      default: state_d = FETCH;
    endcase

    // A timed-out access abandons the instruction and refetches.
    if (expired) begin
      state_d = FETCH;
    end
  end

  // Strobes are qualified by reset so an aborted instruction issues nothing
  // while reset is held; selects follow state, which reset pins at FETCH.
  assign bus.PCWrite     = reset & ~expired & pc_write;
  assign bus.PCWriteCond = reset & pc_write_cond;
  assign bus.IorD        = ior_d;
  assign bus.MemRead     = reset & mem_read;
  assign bus.MemWrite    = reset & ~expired & mem_write;
  assign bus.MemtoReg    = mem_to_reg;
  assign bus.IRWrite     = reset & ~expired & ir_write;
  assign bus.RegWrite    = reset & reg_write;
  assign bus.RegDst      = reg_dst;
  assign bus.ALUSrcA     = alu_src_a;
  assign bus.ALUOp       = alu_op;
  assign bus.ALUSrcB     = alu_src_b;
  assign bus.PCSource    = pc_source;
  assign bus.Ne          = ne;
  assign bus.illegal_op  = reset & illegal;
  assign bus.mem_timeout = reset & expired;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control
//   Directed bench for mc_control. Each cycle the full output word is
//   compared with a hand-written expected word:
//   {state[3:0], illegal_op, mem_timeout,
//    PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
//    RegWrite, RegDst, ALUSrcA, ALUOp, ALUSrcB, PCSource, Ne}
module tb_mc_control;
  import mips_ctrl_pkg::*;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  mc_control_if bus();

  mc_control #(.MAX_WAIT(15)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [23:0] obs;
  assign obs = {bus.state, bus.illegal_op, bus.mem_timeout,
                bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                bus.MemtoReg, bus.IRWrite, bus.RegWrite, bus.RegDst, bus.ALUSrcA,
                bus.ALUOp, bus.ALUSrcB, bus.PCSource, bus.Ne};

  localparam logic [23:0] V_RST        = {4'(FETCH),  2'b00, 10'b0000000000, 8'b00010000};
  localparam logic [23:0] V_FETCH0     = {4'(FETCH),  2'b00, 10'b0001000000, 8'b00010000};
  localparam logic [23:0] V_FETCH1     = {4'(FETCH),  2'b00, 10'b1001001000, 8'b00010000};
  localparam logic [23:0] V_FETCH_TO   = {4'(FETCH),  2'b01, 10'b0001000000, 8'b00010000};
  localparam logic [23:0] V_DECODE     = {4'(DECODE), 2'b00, 10'b0000000000, 8'b00110000};
  localparam logic [23:0] V_DECODE_ILL = {4'(DECODE), 2'b10, 10'b0000000000, 8'b00110000};
  localparam logic [23:0] V_MEMADR     = {4'(MEMADR), 2'b00, 10'b0000000001, 8'b00100000};
  localparam logic [23:0] V_MEMRD      = {4'(MEMRD),  2'b00, 10'b0011000000, 8'b00000000};
  localparam logic [23:0] V_MEMWB      = {4'(MEMWB),  2'b00, 10'b0000010100, 8'b00000000};
  localparam logic [23:0] V_MEMWR      = {4'(MEMWR),  2'b00, 10'b0010100000, 8'b00000000};
  localparam logic [23:0] V_MEMWR_TO   = {4'(MEMWR),  2'b01, 10'b0010000000, 8'b00000000};
  localparam logic [23:0] V_EXEC       = {4'(EXEC),   2'b00, 10'b0000000001, 8'b10000000};
  localparam logic [23:0] V_ALUWB      = {4'(ALUWB),  2'b00, 10'b0000000110, 8'b00000000};
  localparam logic [23:0] V_ADDIEX     = {4'(ADDIEX), 2'b00, 10'b0000000001, 8'b00100000};
  localparam logic [23:0] V_ADDIWB     = {4'(ADDIWB), 2'b00, 10'b0000000100, 8'b00000000};
  localparam logic [23:0] V_BNE        = {4'(BRANCH), 2'b00, 10'b0100000001, 8'b01000101};
  localparam logic [23:0] V_BEQ        = {4'(BRANCH), 2'b00, 10'b0100000001, 8'b01000100};
  localparam logic [23:0] V_JUMP       = {4'(JUMP),   2'b00, 10'b1000000000, 8'b00001010};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.mem_ready = 1'b1;
    bus.OpCode    = 6'b100011;
    reset         = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      n_tests++;
      if (obs !== V_RST) begin
        n_fail++;
        $display("FAIL reset[%0d] got %h want %h", i, obs, V_RST);
      end
    end
    reset = 1'b1;
  endtask

  // lw interrupted by reset in MEMRD, then a clean lw after release.
  task automatic test_lw_reset_abort();
    logic [23:0] e[$];
    logic [0:11] rd = 12'b111_00_0_111111;
    logic [0:11] rs = 12'b11111_00_11111;
    e = '{V_FETCH1, V_DECODE, V_MEMADR, V_MEMRD, V_MEMRD, V_RST, V_RST,
          V_FETCH1, V_DECODE, V_MEMADR, V_MEMRD, V_MEMWB};
    bus.OpCode = 6'b100011;
    for (int i = 0; i < 12; i++) begin
      bus.mem_ready = rd[i];
      reset         = rs[i];
      #1;
      n_tests++;
      if (obs !== e[i]) begin
        n_fail++;
        $display("FAIL lw_reset_abort[%0d] got %h want %h", i, obs, e[i]);
      end
      tick();
    end
  endtask

  task automatic test_rtype();
    logic [23:0] e[$];
    e = '{V_FETCH1, V_DECODE, V_EXEC, V_ALUWB};
    bus.OpCode    = 6'b000000;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < e.size(); i++) begin
      #1;
      n_tests++;
      if (obs !== e[i]) begin
        n_fail++;
        $display("FAIL rtype[%0d] got %h want %h", i, obs, e[i]);
      end
      tick();
    end
  endtask

  task automatic test_addi();
    logic [23:0] e[$];
    e = '{V_FETCH1, V_DECODE, V_ADDIEX, V_ADDIWB};
    bus.OpCode    = 6'b001000;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < e.size(); i++) begin
      #1;
      n_tests++;
      if (obs !== e[i]) begin
        n_fail++;
        $display("FAIL addi[%0d] got %h want %h", i, obs, e[i]);
      end
      tick();
    end
  endtask

  task automatic test_branch(input logic [5:0] op, input logic [23:0] v_br, input string tag);
    logic [23:0] e[$];
    e = '{V_FETCH1, V_DECODE, v_br};
    bus.OpCode    = op;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < e.size(); i++) begin
      #1;
      n_tests++;
      if (obs !== e[i]) begin
        n_fail++;
        $display("FAIL %s[%0d] got %h want %h", tag, i, obs, e[i]);
      end
      tick();
    end
  endtask

  task automatic test_jump();
    logic [23:0] e[$];
    e = '{V_FETCH1, V_DECODE, V_JUMP};
    bus.OpCode    = 6'b000010;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < e.size(); i++) begin
      #1;
      n_tests++;
      if (obs !== e[i]) begin
        n_fail++;
        $display("FAIL jump[%0d] got %h want %h", i, obs, e[i]);
      end
      tick();
    end
  endtask

  task automatic test_illegal();
    logic [23:0] e[$];
    e = '{V_FETCH1, V_DECODE_ILL};
    bus.OpCode    = 6'b111111;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < e.size(); i++) begin
      #1;
      n_tests++;
      if (obs !== e[i]) begin
        n_fail++;
        $display("FAIL illegal[%0d] got %h want %h", i, obs, e[i]);
      end
      tick();
    end
  endtask

  // sw with a stalled write: rdy_at = 0 never readies (timeout),
  // otherwise mem_ready rises on that MEMWR cycle (1-based).
  task automatic test_sw_wait(input int rdy_at, input string tag);
    logic [23:0] e[$];
    bit          r[$];
    e = '{V_FETCH1, V_DECODE, V_MEMADR};
    r = '{1'b1, 1'b1, 1'b0};
    if (rdy_at == 0) begin
      repeat (15) begin
        e.push_back(V_MEMWR);
        r.push_back(1'b0);
      end
      e.push_back(V_MEMWR_TO);
      r.push_back(1'b0);
    end else begin
      repeat (rdy_at - 1) begin
        e.push_back(V_MEMWR);
        r.push_back(1'b0);
      end
      e.push_back(V_MEMWR);
      r.push_back(1'b1);
    end
    bus.OpCode = 6'b101011;
    for (int i = 0; i < e.size(); i++) begin
      bus.mem_ready = r[i];
      #1;
      n_tests++;
      if (obs !== e[i]) begin
        n_fail++;
        $display("FAIL %s[%0d] got %h want %h", tag, i, obs, e[i]);
      end
      tick();
    end
  endtask

  // Stalled instruction fetch: timeout after 15 idle cycles, counter
  // restarts, then a jump completes normally.
  task automatic test_fetch_timeout();
    logic [23:0] e[$];
    bit          r[$];
    repeat (15) begin
      e.push_back(V_FETCH0);
      r.push_back(1'b0);
    end
    e.push_back(V_FETCH_TO); r.push_back(1'b0);
    e.push_back(V_FETCH0);   r.push_back(1'b0);
    e.push_back(V_FETCH0);   r.push_back(1'b0);
    e.push_back(V_FETCH1);   r.push_back(1'b1);
    e.push_back(V_DECODE);   r.push_back(1'b0);
    e.push_back(V_JUMP);     r.push_back(1'b0);
    e.push_back(V_FETCH0);   r.push_back(1'b0);
    bus.OpCode = 6'b000010;
    for (int i = 0; i < e.size(); i++) begin
      bus.mem_ready = r[i];
      #1;
      n_tests++;
      if (obs !== e[i]) begin
        n_fail++;
        $display("FAIL fetch_timeout[%0d] got %h want %h", i, obs, e[i]);
      end
      tick();
    end
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    reset         = 1'b0;
    bus.mem_ready = 1'b0;
    bus.OpCode    = 6'b000000;
    test_reset();
    test_lw_reset_abort();
    test_rtype();
    test_addi();
    test_branch(6'b000101, V_BNE, "bne");
    test_branch(6'b000100, V_BEQ, "beq");
    test_jump();
    test_illegal();
    test_sw_wait(0, "sw_timeout");
    test_sw_wait(15, "sw_ready15");
    test_sw_wait(16, "sw_ready16");
    test_fetch_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15, meaning the maximum number of cycles spent waiting for mem_ready in any memory state.
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset, input, 1, meaning asynchronous active-low reset (0 = reset asserted).
REQ-004 SHALL have port OpCode, input, 6, meaning instruction[31:26] taken from the datapath instruction register.
REQ-005 SHALL have port mem_ready, input, 1, meaning the memory has completed the current read or write.
REQ-006 SHALL have the following outputs, each 1 bit: PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst, ALUSrcA. These are the datapath strobes and mux selects.
REQ-007 SHALL have the following outputs, each 2 bits: ALUOp (00 add, 01 sub, 10 funct), ALUSrcB (00 reg, 01 const 4, 10 sign-extended immediate, 11 shifted immediate), PCSource (00 ALU, 01 ALUOut, 10 jump address), Ne (bit 0 = branch on not-equal, bit 1 = jump select).
REQ-008 SHALL have outputs illegal_op (1 bit), mem_timeout (1 bit) and state (4 bits, the current state encoding).

Function
REQ-009 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH and JUMP. All outputs SHALL decode from state; the FETCH/MEMRD/MEMWR strobes are additionally gated as specified below.
REQ-010 FETCH SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00 and PCSource=00. While mem_ready=1 it SHALL also drive IRWrite=1 and PCWrite=1, then go to DECODE; otherwise it SHALL hold in FETCH.
REQ-011 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11 and ALUOp=00. Its next state depends on OpCode:
- 100011 or 101011 -> MEMADR
- 000000 -> EXEC
- 001000 -> ADDIEX
- 000100 or 000101 -> BRANCH
- 000010 -> JUMP
- any other value -> FETCH, with illegal_op=1 for exactly this one cycle.
REQ-012 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10 and ALUOp=00. It SHALL go to MEMRD when OpCode=100011 and to MEMWR when OpCode=101011.
REQ-013 MEMRD SHALL drive MemRead=1 and IorD=1. It SHALL go to MEMWB when mem_ready=1 and hold otherwise.
REQ-014 MEMWR SHALL drive MemWrite=1 and IorD=1. It SHALL go to FETCH when mem_ready=1 and hold otherwise.
REQ-015 MEMWB SHALL drive RegWrite=1, MemtoReg=1 and RegDst=0, then go to FETCH.
REQ-016 EXEC SHALL drive ALUSrcA=1, ALUSrcB=00 and ALUOp=10, then go to ALUWB. ALUWB SHALL drive RegWrite=1, RegDst=1 and MemtoReg=0, then go to FETCH.
REQ-017 ADDIEX SHALL drive ALUSrcA=1, ALUSrcB=10 and ALUOp=00, then go to ADDIWB. ADDIWB SHALL drive RegWrite=1, RegDst=0 and MemtoReg=0, then go to FETCH.
REQ-018 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, and Ne[0]=1 only when OpCode=000101. It SHALL then go to FETCH.
REQ-019 JUMP SHALL drive PCWrite=1, PCSource=10 and Ne=10, then go to FETCH.
REQ-020 Any output not listed for a state SHALL be 0 in that state.
REQ-021 A wait counter SHALL count consecutive cycles spent in FETCH, MEMRD or MEMWR with mem_ready=0. It SHALL clear on any state change and on mem_ready=1.
REQ-022 When the wait counter reaches MAX_WAIT with mem_ready still 0, the FSM SHALL:
- pulse mem_timeout=1 for one cycle;
- force all write strobes to 0 in that cycle;
- go to FETCH.
REQ-023 If mem_ready=1 in the same cycle the counter reaches MAX_WAIT, the FSM SHALL complete the access normally, with no timeout.
REQ-024 Latencies from the first FETCH cycle, with zero wait: lw 5 cycles, sw 4, R-type 4, addi 4, beq/bne 3, j 3.
REQ-025 The unused state encodings SHALL transition to FETCH on the next clock.

Reset
REQ-026 While reset=0, the FSM SHALL:
- set state=FETCH;
- clear the wait counter;
- force PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, illegal_op and mem_timeout to 0;
- hold all mux selects at their FETCH values.
REQ-027 Reset asserted mid-instruction SHALL abort that instruction immediately, with no further write strobe issued. Execution SHALL restart in FETCH on the first clock after reset=1.

Structure
REQ-028 A shared package mips_ctrl_pkg SHALL hold the 4-bit state encodings, the opcode constants (RTYPE, LW, SW, BEQ, BNE, ADDI, J), and the ALUOp, ALUSrcB and PCSource codes.
REQ-029 The wait counter SHALL be a sub-module mem_wait_timer. It SHALL have inputs clk, reset, active and ready, and output expired, and SHALL be sized by MAX_WAIT.

Verification
REQ-030 Drive reset=0 mid-MEMRD, then release with mem_ready=1 and OpCode=100011. Required response: all strobes 0 during reset, then state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, with RegWrite=1 and MemtoReg=1 in the fifth cycle.
REQ-031 Run OpCode=000000 with mem_ready=1. Required response: ALUOp=10 in EXEC, RegWrite=1 and RegDst=1 in ALUWB, and a return to FETCH after 4 cycles.
REQ-032 Run OpCode=000101 and then OpCode=000100. Required response: in BRANCH, PCWriteCond=1, PCSource=01, ALUOp=01, with Ne=01 for bne and Ne=00 for beq.
REQ-033 Run OpCode=000010. Required response: in JUMP, PCWrite=1, PCSource=10, Ne=10; FETCH follows.
REQ-034 Present OpCode=111111. Required response: illegal_op=1 for exactly one DECODE cycle, then FETCH, with no RegWrite or MemWrite issued.
REQ-035 Run sw with mem_ready held at 0 for MAX_WAIT=15 cycles. Required response: MemWrite=1 for 15 cycles, mem_timeout=1 for one cycle, then FETCH. Repeat with mem_ready=1 arriving on cycle 15. Required response: normal completion with no timeout.
